// File: rtl/serial_tx_if.sv
// serial_tx_if: upstream word handshake plus serial line and status for serial_tx.
// master drives the word/valid; slave (the transmitter) drives ready, line and busy.
interface serial_tx_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic              tx_out;
   logic              busy;

   modport master (
      output tx_data,
      output tx_valid,
      input  tx_ready,
      input  tx_out,
      input  busy
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      output tx_ready,
      output tx_out,
      output busy
   );
endinterface

// File: rtl/serial_tx.sv
// serial_tx: start, DATA_W bits LSB first, optional even parity (SERIAL_TX_PARITY_EN), stop; line drops the cycle after accept.
// tx_ready is high only in IDLE, so upstream stalls for the whole frame plus at least one idle cycle.
module serial_tx #(
   parameter int DATA_W     = 8,
   parameter int BIT_CYCLES = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   serial_tx_if.slave bus
);
   localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

`ifdef SERIAL_TX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   state_t            state_q, state_d;
   logic [CW-1:0]     cyc_q, cyc_d;
   logic [BW-1:0]     bit_q, bit_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              tx_out_q, tx_out_d;
   logic              busy_q;
   logic              ready_q;
   logic              bit_end;
`ifdef SERIAL_TX_PARITY_EN
   logic              parity_q, parity_d;
`endif

   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      bit_d   = bit_q;
      shift_d = shift_q;
`ifdef SERIAL_TX_PARITY_EN
      parity_d = parity_q;
`endif
      bit_end = (cyc_q == CYC_LAST);

      if (state_q != S_IDLE) begin
         cyc_d = bit_end ? '0 : cyc_q + CW'(1);
      end

      case (state_q)
         S_IDLE: begin
            if (bus.tx_valid) begin
               shift_d = bus.tx_data;
`ifdef SERIAL_TX_PARITY_EN
               parity_d = ^bus.tx_data;
`endif
               cyc_d   = '0;
               state_d = S_START;
            end
         end
         S_START: begin
            if (bit_end) begin
               bit_d   = '0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               shift_d = shift_q >> 1;
               if (bit_q == BIT_LAST) begin
                  bit_d = '0;
`ifdef SERIAL_TX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  bit_d = bit_q + BW'(1);
               end
            end
         end
`ifdef SERIAL_TX_PARITY_EN
         S_PARITY: begin
            if (bit_end) state_d = S_STOP;
         end
`endif
         S_STOP: begin
            if (bit_end) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Line value is decoded from the next state so tx_out is a plain flop.
      tx_out_d = 1'b1;
      case (state_d)
         S_START:  tx_out_d = 1'b0;
         S_DATA:   tx_out_d = shift_d[0];
`ifdef SERIAL_TX_PARITY_EN
         S_PARITY: tx_out_d = parity_d;
`endif
         default:  tx_out_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         cyc_q    <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         tx_out_q <= 1'b1;
         busy_q   <= 1'b0;
         ready_q  <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cyc_q    <= cyc_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         tx_out_q <= tx_out_d;
         busy_q   <= (state_d != S_IDLE);
         ready_q  <= (state_d == S_IDLE);
`ifdef SERIAL_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   assign bus.tx_out   = tx_out_q;
   assign bus.busy     = busy_q;
   assign bus.tx_ready = ready_q;
endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: two instances (BIT_CYCLES 4 and 1) checked every cycle against a queue-of-line-bits model.
module tb_serial_tx;
   localparam int DW = 8;
`ifdef SERIAL_TX_PARITY_EN
   localparam int NBITS = DW + 3;
`else
   localparam int NBITS = DW + 2;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   vectors = 0;
   int   errors  = 0;

   always #5 clk = ~clk;

   serial_tx_if #(.DATA_W(DW)) if0();
   serial_tx_if #(.DATA_W(DW)) if1();

   serial_tx #(.DATA_W(DW), .BIT_CYCLES(4)) u0 (.clk_i(clk), .rst_i(rst), .bus(if0));
   serial_tx #(.DATA_W(DW), .BIT_CYCLES(1)) u1 (.clk_i(clk), .rst_i(rst), .bus(if1));

   // Expected line level for every future cycle of the frame in flight; empty means idle.
   bit q0[$];
   bit q1[$];

   function automatic bit bit_of(input logic [DW-1:0] d, input int k);
      if (k == 0) return 1'b0;
      if (k <= DW) return d[k-1];
`ifdef SERIAL_TX_PARITY_EN
      if (k == DW + 1) return ^d;
`endif
      return 1'b1;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q0.delete();
         q1.delete();
      end else begin
         if (q0.size() == 0) begin
            if (if0.tx_valid === 1'b1)
               for (int k = 0; k < NBITS; k++) repeat (4) q0.push_back(bit_of(if0.tx_data, k));
         end else begin
            void'(q0.pop_front());
         end
         if (q1.size() == 0) begin
            if (if1.tx_valid === 1'b1)
               for (int k = 0; k < NBITS; k++) q1.push_back(bit_of(if1.tx_data, k));
         end else begin
            void'(q1.pop_front());
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("u0.tx_out",   32'(if0.tx_out),   32'(q0.size() != 0 ? q0[0] : 1'b1));
      chk("u0.busy",     32'(if0.busy),     32'(q0.size() != 0));
      chk("u0.tx_ready", 32'(if0.tx_ready), 32'(q0.size() == 0));
      chk("u1.tx_out",   32'(if1.tx_out),   32'(q1.size() != 0 ? q1[0] : 1'b1));
      chk("u1.busy",     32'(if1.busy),     32'(q1.size() != 0));
      chk("u1.tx_ready", 32'(if1.tx_ready), 32'(q1.size() == 0));
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_idle(input int lim);
      int n = 0;
      while (!(if0.tx_ready === 1'b1 && if1.tx_ready === 1'b1) && n < lim) begin
         @(negedge clk);
         n++;
      end
      chk("wait_idle.ready", 32'(if0.tx_ready & if1.tx_ready), 32'd1);
   endtask

   task automatic send1(input logic [DW-1:0] d, input bit exp[NBITS], input string tag);
      tick();
      if1.tx_data  = d;
      if1.tx_valid = 1'b1;
      @(posedge clk);
      #2 if1.tx_valid = 1'b0;
      for (int i = 0; i < NBITS; i++) begin
         @(negedge clk);
         chk($sformatf("%s.bit%0d", tag, i), 32'(if1.tx_out), 32'(exp[i]));
      end
      @(negedge clk);
      chk({tag, ".ready_after"}, 32'(if1.tx_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1);
   end

   initial begin
      bit   ea5[NBITS];
      bit   e80[NBITS];
      bit   e01[NBITS];
      logic cap[NBITS*4];
      logic all_busy, any_ready;
      int   n, gap;

`ifdef SERIAL_TX_PARITY_EN
      ea5 = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
      e80 = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
      e01 = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1};
`else
      ea5 = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
      e80 = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
      e01 = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 1};
`endif
      if0.tx_valid = 1'b0; if0.tx_data = '0;
      if1.tx_valid = 1'b0; if1.tx_data = '0;

      #2 rst = 1'b1;
      #1;
      chk("reset.tx_out", 32'(if0.tx_out), 32'd1);
      chk("reset.busy",   32'(if0.busy),   32'd0);
      chk("reset.ready",  32'(if0.tx_ready), 32'd1);
      repeat (2) tick();
      rst = 1'b0;

      // 0xA5 with tx_data switched to 0x3C right after accept, valid held high.
      tick();
      if0.tx_data  = 8'hA5;
      if0.tx_valid = 1'b1;
      @(posedge clk);
      #2 if0.tx_data = 8'h3C;
      all_busy = 1'b1;
      any_ready = 1'b0;
      for (int i = 0; i < NBITS*4; i++) begin
         @(negedge clk);
         cap[i]    = if0.tx_out;
         all_busy  = all_busy & if0.busy;
         any_ready = any_ready | if0.tx_ready;
      end
      for (int i = 0; i < NBITS*4; i++)
         chk($sformatf("a5.cycle%0d", i), 32'(cap[i]), 32'(ea5[i/4]));
      chk("a5.busy_all", 32'(all_busy), 32'd1);
      chk("a5.ready_none", 32'(any_ready), 32'd0);
      @(negedge clk);
      chk("a5.ready_after", 32'(if0.tx_ready), 32'd1);
      @(posedge clk);
      #2 if0.tx_valid = 1'b0;
      wait_idle(400);

      // Back-to-back 0x00 then 0xFF with valid held high.
      tick();
      if0.tx_data  = 8'h00;
      if0.tx_valid = 1'b1;
      @(posedge clk);
      #2 if0.tx_data = 8'hFF;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (if0.busy === 1'b1 && n < 400);
      gap = 0;
      while (if0.busy !== 1'b1 && gap < 10) begin
         gap++;
         @(negedge clk);
      end
      chk("b2b.idle_gap", 32'(gap), 32'd1);
      @(posedge clk);
      #2 if0.tx_valid = 1'b0;
      wait_idle(400);

      send1(8'h80, e80, "bc1_80");
      send1(8'h01, e01, "bc1_01");

      // Reset during data bit 3 of a 0xA5 frame.
      tick();
      if0.tx_data  = 8'hA5;
      if0.tx_valid = 1'b1;
      @(posedge clk);
      #2 if0.tx_valid = 1'b0;
      repeat (17) @(posedge clk);
      #3;
      chk("midrst.pre_busy", 32'(if0.busy), 32'd1);
      rst = 1'b1;
      #1;
      chk("midrst.tx_out", 32'(if0.tx_out), 32'd1);
      chk("midrst.busy",   32'(if0.busy),   32'd0);
      chk("midrst.ready",  32'(if0.tx_ready), 32'd1);
      repeat (2) tick();
      rst = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         chk("midrst.line_high", 32'(if0.tx_out), 32'd1);
      end

      // Random traffic; tx_data churns every cycle including mid-frame.
      for (int i = 0; i < 3000; i++) begin
         tick();
         if0.tx_valid = ($urandom_range(0, 3) == 0);
         if0.tx_data  = DW'($urandom);
         if1.tx_valid = ($urandom_range(0, 2) == 0);
         if1.tx_data  = DW'($urandom);
      end
      tick();
      if0.tx_valid = 1'b0;
      if1.tx_valid = 1'b0;
      repeat (2) tick();
      wait_idle(400);
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
Serial transmitter for a single-wire, frame-based link: start bit, DATA_W data bits LSB first, optional parity bit, stop bit. Drives the bit line that a flip-flop/shift-register receiver samples at the far end. Parallel word accepted via valid/ready handshake from upstream logic; line held high when idle.

Parameters:
DATA_W, 8, data bits per frame (>=1)
BIT_CYCLES, 4, clk cycles each bit is held on tx_out (>=1)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
tx_data  input  DATA_W  word to send; sampled only on accept edge
tx_valid  input  1  upstream has a word on tx_data
tx_ready  output  1  block can accept a word this cycle
tx_out  output  1  serial line, idle high
busy  output  1  frame in progress (any state other than IDLE)

Behaviour:
- Reset (async, active-high): state=IDLE, tx_out=1, tx_ready=1, busy=0, bit counter=0, cycle counter=0, shift register=0. Takes effect immediately, not on the next edge.
- Reset mid-frame: frame aborted, tx_out returns high at once, no partial frame resumes after release.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- Accept: rising edge with tx_valid=1 and tx_ready=1. tx_data latched into shift register; state -> START.
- tx_ready=1 only in IDLE; tx_valid outside IDLE is ignored and does not latch data.
- All outputs registered. tx_out=0 in the cycle immediately after the accept edge.
- Each bit held exactly BIT_CYCLES cycles; cycle counter runs 0..BIT_CYCLES-1 and wraps to 0 on each bit boundary.
- START: tx_out=0.
- DATA: tx_out=shift[0]; shift right once per bit boundary; bit counter 0..DATA_W-1. Leaves DATA after bit DATA_W-1 completes.
- STOP: tx_out=1 for BIT_CYCLES cycles, then IDLE.
- Frame length: (DATA_W+2)*BIT_CYCLES cycles, or (DATA_W+3)*BIT_CYCLES cycles with parity.
- Back-to-back frames: IDLE lasts at least one cycle between frames, so there is at least one idle-high cycle after the stop bit.
- BIT_CYCLES=1: each bit lasts exactly one cycle; no counter underflow or wrap errors.
- busy = (state != IDLE), registered in step with state.

Optional Feature:
Macro: SERIAL_TX_PARITY_EN
- Defined: PARITY state inserted between DATA and STOP. tx_out = even parity (XOR of the latched word) for BIT_CYCLES cycles. Parity is computed from the word at the accept edge.
- Undefined: no PARITY state; DATA goes directly to STOP. Frame is (DATA_W+2)*BIT_CYCLES cycles.

Test Plan:
- DATA_W=8, BIT_CYCLES=4; send 0xA5 -> tx_out sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles total); tx_ready=0 and busy=1 throughout; tx_ready=1 on the following cycle.
- Same frame with SERIAL_TX_PARITY_EN defined -> parity bit 0 inserted before stop; 44 cycles total. Repeat with 0x01 -> parity bit 1.
- tx_valid held high with 0x00 then 0xFF queued -> two complete frames separated by exactly one idle-high cycle; second frame carries 0xFF, not a corrupted value.
- tx_data changed to 0x3C mid-frame while tx_valid=1 -> in-flight 0xA5 frame unchanged; 0x3C sent only after tx_ready returns high.
- Assert reset during data bit 3 (between clk edges) -> tx_out=1, busy=0, tx_ready=1 immediately; after release the line stays high until a new accept.
- BIT_CYCLES=1, send 0x80 -> tx_out 0,0,0,0,0,0,0,0,1,1 on consecutive cycles; 10-cycle frame.
